alu_pipe: RTL and testbench

- Parametrised, pipelined integer execution unit; successor to the single-cycle combinational ALU.
- Accepts one operation per cycle from the ALU reservation station through a valid/ready handshake.
- Carries the ROB tag with each operation and presents tagged results to the CDB arbiter.
- Supports signed/unsigned compares, arithmetic shift, full-pipeline backpressure and misprediction flush.

---
 rtl/alu_pipe.sv | 169 ++++++++++++++++
 tb/tb_alu_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Pipelined integer execution unit. One operation per cycle is accepted from
// the reservation station over a valid/ready handshake. The result is
// computed combinationally on entry to stage 0 and registered there. Later
// stages only carry {valid, result, tag} towards the CDB, so the
// issue-to-result latency is STAGES cycles.
//
// Parameters
//   XLEN    operand/result width (8..64, power of two)
//   TAG_W   ROB tag width
//   STAGES  pipeline depth = issue-to-result latency (1..4)
//
// Ports
//   clk_in      clock
//   rst_in      synchronous active-high reset, overrides rdy_in
//   rdy_in      global enable; low freezes every register
//   flush_in    misprediction rollback, kills every in-flight op
//   in_valid    issue request from the reservation station
//   in_ready    unit accepts an op this cycle
//   in_op       operation code (0..15)
//   in_op1      operand 1
//   in_op2      operand 2
//   in_tag      ROB tag travelling with the op
//   out_valid   result available for the CDB
//   out_ready   CDB grant
//   out_result  result of the oldest op
//   out_tag     ROB tag of that result
//   busy        some stage holds a valid op
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int SHW = $clog2(XLEN);

    logic [STAGES-1:0] stageValid_q;
    logic [STAGES-1:0] stageValid_d;
    logic [XLEN-1:0]   stageResult_q [STAGES];
    logic [XLEN-1:0]   stageResult_d [STAGES];
    logic [TAG_W-1:0]  stageTag_q [STAGES];
    logic [TAG_W-1:0]  stageTag_d [STAGES];

    logic [STAGES-1:0] advance;
    logic              chainGo;
    logic              stage0Free;
    logic              accept;
    logic [SHW-1:0]    shiftAmount;
    logic [XLEN-1:0]   aluResult;

    // The ALU proper. Only the low log2(XLEN) bits of op2 select the shift
    // distance. Compares return a single flag in bit 0 with the upper bits
    // zero. Op code 15 is reserved and produces zero.
    always_comb begin
        shiftAmount = in_op2[SHW-1:0];
        aluResult   = '0;
        case (in_op)
            4'd0:    aluResult = in_op1 + in_op2;
            4'd1:    aluResult = in_op1 - in_op2;
            4'd2:    aluResult = in_op1 & in_op2;
            4'd3:    aluResult = in_op1 | in_op2;
            4'd4:    aluResult = in_op1 ^ in_op2;
            4'd5:    aluResult = in_op1 << shiftAmount;
            4'd6:    aluResult = in_op1 >> shiftAmount;
            4'd7:    aluResult = $unsigned($signed(in_op1) >>> shiftAmount);
            4'd8:    aluResult = {{(XLEN-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
            4'd9:    aluResult = {{(XLEN-1){1'b0}}, in_op1 < in_op2};
            4'd10:   aluResult = {{(XLEN-1){1'b0}}, in_op1 == in_op2};
            4'd11:   aluResult = {{(XLEN-1){1'b0}}, in_op1 != in_op2};
            4'd12:   aluResult = {{(XLEN-1){1'b0}}, $signed(in_op1) >= $signed(in_op2)};
            4'd13:   aluResult = {{(XLEN-1){1'b0}}, in_op1 >= in_op2};
            4'd14:   aluResult = in_op2;
            default: aluResult = '0;
        endcase
    end

    // Backpressure chain, walked from the output end back towards stage 0.
    // A stage moves on when it holds an op and whatever is downstream of it
    // will make room this cycle (the CDB grant for the last stage, otherwise
    // an empty or itself-advancing next stage). What is left in chainGo at
    // the end tells whether stage 0 can take a new op, which is why in_ready
    // follows out_ready combinationally through a full pipe.
    always_comb begin
        advance = '0;
        chainGo = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            advance[k] = stageValid_q[k] && chainGo;
            chainGo    = !stageValid_q[k] || advance[k];
        end
        stage0Free = chainGo;
    end

    assign in_ready = rdy_in && !flush_in && stage0Free;
    assign accept   = in_valid && in_ready;

    // Next-state for every stage. With rdy_in low nothing moves at all,
    // flush included. A flush only clears the valid bits; the stale payload
    // left behind is never presented because out_valid stays low. Each
    // stage either loads from the stage before it, empties because its op
    // moved on, or holds.
    always_comb begin
        stageValid_d  = stageValid_q;
        stageResult_d = stageResult_q;
        stageTag_d    = stageTag_q;
        if (rdy_in) begin
            if (flush_in) begin
                stageValid_d = '0;
            end else begin
                for (int k = STAGES - 1; k >= 1; k--) begin
                    if (advance[k-1]) begin
                        stageValid_d[k]  = 1'b1;
                        stageResult_d[k] = stageResult_q[k-1];
                        stageTag_d[k]    = stageTag_q[k-1];
                    end else if (advance[k]) begin
                        stageValid_d[k] = 1'b0;
                    end
                end
                if (accept) begin
                    stageValid_d[0]  = 1'b1;
                    stageResult_d[0] = aluResult;
                    stageTag_d[0]    = in_tag;
                end else if (advance[0]) begin
                    stageValid_d[0] = 1'b0;
                end
            end
        end
    end

    // Stage registers. Reset clears the payload as well as the valid bits
    // so that out_result and out_tag read zero straight after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stageValid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stageResult_q[k] <= '0;
                stageTag_q[k]    <= '0;
            end
        end else begin
            stageValid_q  <= stageValid_d;
            stageResult_q <= stageResult_d;
            stageTag_q    <= stageTag_d;
        end
    end

    assign out_valid  = stageValid_q[STAGES-1];
    assign out_result = stageResult_q[STAGES-1];
    assign out_tag    = stageTag_q[STAGES-1];
    assign busy       = |stageValid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Three alu_pipe instances share one set of inputs: A (XLEN=32, STAGES=2),
// B (XLEN=64, STAGES=4) and C (XLEN=32, STAGES=1). Directed steps exercise A
// in detail and B/C on latency and reset. A randomized phase then drives
// all three together against an in-order scoreboard whose expected results
// come from a plain-arithmetic ALU model.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rdy;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [3:0]  inOp;
    logic [63:0] inOp1;
    logic [63:0] inOp2;
    logic [3:0]  inTag;

    logic        inReadyA, outValidA, busyA;
    logic [31:0] outResultA;
    logic [3:0]  outTagA;
    logic        inReadyB, outValidB, busyB;
    logic [63:0] outResultB;
    logic [3:0]  outTagB;
    logic        inReadyC, outValidC, busyC;
    logic [31:0] outResultC;
    logic [3:0]  outTagC;

    int checks = 0;
    int errors = 0;

    logic [67:0] sbQ [3][$];
    logic [3:0]  t2Op [7];
    logic [31:0] t2Exp [7];

    alu_pipe #(.XLEN(32), .TAG_W(4), .STAGES(2)) dutA (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .in_valid(inValid), .in_ready(inReadyA), .in_op(inOp),
        .in_op1(inOp1[31:0]), .in_op2(inOp2[31:0]), .in_tag(inTag),
        .out_valid(outValidA), .out_ready(outReady), .out_result(outResultA),
        .out_tag(outTagA), .busy(busyA)
    );

    alu_pipe #(.XLEN(64), .TAG_W(4), .STAGES(4)) dutB (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .in_valid(inValid), .in_ready(inReadyB), .in_op(inOp),
        .in_op1(inOp1), .in_op2(inOp2), .in_tag(inTag),
        .out_valid(outValidB), .out_ready(outReady), .out_result(outResultB),
        .out_tag(outTagB), .busy(busyB)
    );

    alu_pipe #(.XLEN(32), .TAG_W(4), .STAGES(1)) dutC (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .in_valid(inValid), .in_ready(inReadyC), .in_op(inOp),
        .in_op1(inOp1[31:0]), .in_op2(inOp2[31:0]), .in_tag(inTag),
        .out_valid(outValidC), .out_ready(outReady), .out_result(outResultC),
        .out_tag(outTagC), .busy(busyC)
    );

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // Moves to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one issue slot; the values are sampled at the next rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] tag);
        inValid = v;
        inOp    = op;
        inOp1   = a;
        inOp2   = b;
        inTag   = tag;
    endtask

    // Reference ALU written from the op-code table with ordinary arithmetic
    // on 64-bit values, then reduced to the instance width.
    function automatic logic [63:0] refAlu(input int xlen, input logic [3:0] op,
                                           input logic [63:0] aIn, input logic [63:0] bIn);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        longint      sa;
        longint      sb;
        int          sh;
        mask = (xlen == 64) ? '1 : ((64'd1 << xlen) - 64'd1);
        a  = aIn & mask;
        b  = bIn & mask;
        sa = longint'(a);
        sb = longint'(b);
        if (xlen < 64) begin
            if (a[xlen-1]) sa = sa - (longint'(1) << xlen);
            if (b[xlen-1]) sb = sb - (longint'(1) << xlen);
        end
        sh = int'(b % 64'(xlen));
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sh;
            4'd6:    r = a >> sh;
            4'd7:    r = 64'(sa >>> sh);
            4'd8:    r = {63'd0, sa < sb};
            4'd9:    r = {63'd0, a < b};
            4'd10:   r = {63'd0, a == b};
            4'd11:   r = {63'd0, a != b};
            4'd12:   r = {63'd0, sa >= sb};
            4'd13:   r = {63'd0, a >= b};
            4'd14:   r = b;
            default: r = 64'd0;
        endcase
        return r & mask;
    endfunction

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h0000_0000_8000_0000;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboard step for one instance, called once per cycle after the
    // inputs have settled. The queue holds every op accepted and neither
    // delivered nor flushed, oldest first.
    task automatic scoreDut(input int idx, input int xlen, input int stages,
                            input logic inReadyX, input logic outValidX,
                            input logic [63:0] outResultX, input logic [3:0] outTagX,
                            input logic busyX);
        logic        modelReady;
        logic [67:0] head;
        modelReady = rdy && !flush && ((sbQ[idx].size() < stages) || outReady);
        checkOutput($sformatf("rand_d%0d_in_ready", idx), 64'(inReadyX), 64'(modelReady));
        checkOutput($sformatf("rand_d%0d_busy", idx), 64'(busyX), 64'(sbQ[idx].size() != 0));
        if (sbQ[idx].size() == 0) begin
            checkOutput($sformatf("rand_d%0d_valid_when_empty", idx), 64'(outValidX), 64'd0);
        end else if (rdy && outValidX && outReady) begin
            head = sbQ[idx].pop_front();
            checkOutput($sformatf("rand_d%0d_result", idx), outResultX, head[63:0]);
            checkOutput($sformatf("rand_d%0d_tag", idx), 64'(outTagX), 64'(head[67:64]));
        end
        if (rdy && flush) sbQ[idx].delete();
        if (inValid && modelReady) sbQ[idx].push_back({inTag, refAlu(xlen, inOp, inOp1, inOp2)});
    endtask

    task automatic scoreAll();
        scoreDut(0, 32, 2, inReadyA, outValidA, {32'd0, outResultA}, outTagA, busyA);
        scoreDut(1, 64, 4, inReadyB, outValidB, outResultB, outTagB, busyB);
        scoreDut(2, 32, 1, inReadyC, outValidC, {32'd0, outResultC}, outTagC, busyC);
    endtask

    // The whole directed sequence followed by the randomized phase.
    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        flush    = 1'b0;
        outReady = 1'b1;
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("reset_out_valid", 64'(outValidA), 64'd0);
        checkOutput("reset_out_result", 64'(outResultA), 64'd0);
        checkOutput("reset_out_tag", 64'(outTagA), 64'd0);
        checkOutput("reset_busy", 64'(busyA), 64'd0);
        checkOutput("reset_in_ready", 64'(inReadyA), 64'd1);

        $display("[TB] back-to-back ADD/SUB/SRA");
        applyStimulus(1'b1, 4'd0, 64'd5, 64'd7, 4'd3);
        tick();
        applyStimulus(1'b1, 4'd1, 64'd0, 64'd1, 4'd4);
        #1;
        checkOutput("b2b_not_yet_valid", 64'(outValidA), 64'd0);
        tick();
        applyStimulus(1'b1, 4'd7, 64'h8000_0000, 64'd4, 4'd5);
        #1;
        checkOutput("b2b_add_valid", 64'(outValidA), 64'd1);
        checkOutput("b2b_add_result", 64'(outResultA), 64'd12);
        checkOutput("b2b_add_tag", 64'(outTagA), 64'd3);
        tick();
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        #1;
        checkOutput("b2b_sub_result", 64'(outResultA), 64'hFFFF_FFFF);
        checkOutput("b2b_sub_tag", 64'(outTagA), 64'd4);
        tick();
        #1;
        checkOutput("b2b_sra_result", 64'(outResultA), 64'hF800_0000);
        checkOutput("b2b_sra_tag", 64'(outTagA), 64'd5);
        tick();
        #1;
        checkOutput("b2b_drained_valid", 64'(outValidA), 64'd0);
        checkOutput("b2b_drained_busy", 64'(busyA), 64'd0);

        $display("[TB] compares and masked shift amount");
        t2Op  = '{4'd8, 4'd9, 4'd12, 4'd13, 4'd10, 4'd11, 4'd5};
        t2Exp = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd2};
        for (int i = 0; i < 9; i++) begin
            if (i < 6) applyStimulus(1'b1, t2Op[i], 64'hFFFF_FFFF, 64'd1, 4'(i));
            else if (i == 6) applyStimulus(1'b1, t2Op[i], 64'd1, 64'h21, 4'(i));
            else applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
            #1;
            if (i >= 2) begin
                checkOutput($sformatf("cmp%0d_valid", i - 2), 64'(outValidA), 64'd1);
                checkOutput($sformatf("cmp%0d_result", i - 2), 64'(outResultA), 64'(t2Exp[i-2]));
                checkOutput($sformatf("cmp%0d_tag", i - 2), 64'(outTagA), 64'(i - 2));
            end
            tick();
        end

        $display("[TB] backpressure");
        outReady = 1'b0;
        applyStimulus(1'b1, 4'd0, 64'd1, 64'd1, 4'd1);
        #1;
        checkOutput("bp_ready_0", 64'(inReadyA), 64'd1);
        tick();
        applyStimulus(1'b1, 4'd0, 64'd2, 64'd2, 4'd2);
        #1;
        checkOutput("bp_ready_1", 64'(inReadyA), 64'd1);
        tick();
        applyStimulus(1'b1, 4'd0, 64'd3, 64'd3, 4'd6);
        #1;
        checkOutput("bp_full_ready", 64'(inReadyA), 64'd0);
        checkOutput("bp_head_valid", 64'(outValidA), 64'd1);
        checkOutput("bp_head_result", 64'(outResultA), 64'd2);
        tick();
        #1;
        checkOutput("bp_hold_ready", 64'(inReadyA), 64'd0);
        checkOutput("bp_hold_result", 64'(outResultA), 64'd2);
        checkOutput("bp_hold_tag", 64'(outTagA), 64'd1);
        outReady = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(inReadyA), 64'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        #1;
        checkOutput("bp_second_result", 64'(outResultA), 64'd4);
        checkOutput("bp_second_tag", 64'(outTagA), 64'd2);
        tick();
        #1;
        checkOutput("bp_third_result", 64'(outResultA), 64'd6);
        checkOutput("bp_third_tag", 64'(outTagA), 64'd6);
        tick();
        #1;
        checkOutput("bp_empty_valid", 64'(outValidA), 64'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 4'd0, 64'd10, 64'd10, 4'd7);
        tick();
        applyStimulus(1'b1, 4'd0, 64'd20, 64'd20, 4'd8);
        tick();
        applyStimulus(1'b1, 4'd0, 64'd30, 64'd30, 4'd9);
        flush    = 1'b1;
        outReady = 1'b0;
        #1;
        checkOutput("flush_in_ready", 64'(inReadyA), 64'd0);
        checkOutput("flush_presented_tag", 64'(outTagA), 64'd7);
        tick();
        flush    = 1'b0;
        outReady = 1'b1;
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        #1;
        checkOutput("flush_busy", 64'(busyA), 64'd0);
        checkOutput("flush_in_ready_after", 64'(inReadyA), 64'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("flush_no_result_%0d", i), 64'(outValidA), 64'd0);
            tick();
        end

        $display("[TB] rdy_in low");
        applyStimulus(1'b1, 4'd0, 64'd100, 64'd1, 4'd10);
        tick();
        rdy = 1'b0;
        applyStimulus(1'b1, 4'd0, 64'd200, 64'd2, 4'd11);
        #1;
        checkOutput("frz_in_ready_0", 64'(inReadyA), 64'd0);
        tick();
        flush = 1'b1;
        #1;
        checkOutput("frz_in_ready_1", 64'(inReadyA), 64'd0);
        checkOutput("frz_busy", 64'(busyA), 64'd1);
        checkOutput("frz_valid_1", 64'(outValidA), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("frz_in_ready_2", 64'(inReadyA), 64'd0);
        tick();
        rdy = 1'b1;
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        #1;
        checkOutput("frz_still_pending", 64'(outValidA), 64'd0);
        tick();
        #1;
        checkOutput("frz_late_valid", 64'(outValidA), 64'd1);
        checkOutput("frz_late_result", 64'(outResultA), 64'd101);
        checkOutput("frz_late_tag", 64'(outTagA), 64'd10);
        tick();
        #1;
        checkOutput("frz_nothing_else", 64'(outValidA), 64'd0);
        checkOutput("frz_idle_busy", 64'(busyA), 64'd0);

        $display("[TB] STAGES=1 and XLEN=64 latency");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 4'd7, 64'h8000_0000_0000_0000, 64'd63, 4'd2);
        tick();
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        #1;
        checkOutput("c_valid", 64'(outValidC), 64'd1);
        checkOutput("c_result", 64'(outResultC), 64'd0);
        checkOutput("c_tag", 64'(outTagC), 64'd2);
        checkOutput("b_busy", 64'(busyB), 64'd1);
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("b_not_yet_%0d", i), 64'(outValidB), 64'd0);
            tick();
        end
        checkOutput("b_valid", 64'(outValidB), 64'd1);
        checkOutput("b_sra_result", outResultB, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("b_sra_tag", 64'(outTagB), 64'd2);
        tick();
        checkOutput("b_drained", 64'(outValidB), 64'd0);

        $display("[TB] reset with ops in flight");
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd0, 64'(i + 1), 64'd40, 4'(12 + i));
            tick();
        end
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        rst = 1'b1;
        rdy = 1'b0;
        tick();
        rst      = 1'b0;
        rdy      = 1'b1;
        outReady = 1'b1;
        #1;
        checkOutput("rst_a_valid", 64'(outValidA), 64'd0);
        checkOutput("rst_a_result", 64'(outResultA), 64'd0);
        checkOutput("rst_a_busy", 64'(busyA), 64'd0);
        checkOutput("rst_a_in_ready", 64'(inReadyA), 64'd1);
        checkOutput("rst_b_valid", 64'(outValidB), 64'd0);
        checkOutput("rst_b_result", outResultB, 64'd0);
        checkOutput("rst_b_tag", 64'(outTagB), 64'd0);
        checkOutput("rst_b_busy", 64'(busyB), 64'd0);
        checkOutput("rst_c_valid", 64'(outValidC), 64'd0);
        checkOutput("rst_c_busy", 64'(busyC), 64'd0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 500; cyc++) begin
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                          pickOperand(), pickOperand(), 4'($urandom));
            outReady = ($urandom_range(0, 9) < 6);
            rdy      = ($urandom_range(0, 19) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            #1;
            scoreAll();
            tick();
        end
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        outReady = 1'b1;
        rdy      = 1'b1;
        flush    = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            scoreAll();
            tick();
        end
        checkOutput("final_a_busy", 64'(busyA), 64'd0);
        checkOutput("final_b_busy", 64'(busyB), 64'd0);
        checkOutput("final_c_busy", 64'(busyC), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
